// File: rtl/data_mem_bytelane.sv
// Byte-addressable data memory with per-lane stores, sign/zero-extending loads,
// a registered read port and a one-word-per-cycle clear sweep after reset.
module data_mem_bytelane #(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              WE,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              rvalid,
  output logic              ready,
  output logic              misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0] mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             ready_q, ready_d;
  logic             rvalid_q, rvalid_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      rd_q, rd_d;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic             accept;
  logic             legal;
  logic [3:0]       lane_en;
  logic [31:0]      store_data;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;

  logic [3:0]       mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;

  assign word_idx = A[IDX_W+1:2];
  assign offset   = A[1:0];
  assign accept   = req & ready_q & ~rst;
  assign rd_word  = mem[word_idx];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    legal      = 1'b0;
    lane_en    = 4'b0000;
    store_data = WD;
    unique case (size)
      SZ_BYTE: begin
        legal      = 1'b1;
        lane_en    = 4'b0001 << offset;
        store_data = {4{WD[7:0]}};
      end
      SZ_HALF: begin
        legal      = ~offset[0];
        lane_en    = offset[1] ? 4'b1100 : 4'b0011;
        store_data = {2{WD[15:0]}};
      end
      SZ_WORD: begin
        legal   = (offset == 2'b00);
        lane_en = 4'b1111;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Lane select for loads; the width of the extension is set by the access size.
  always_comb begin
    load_byte = rd_word[8*offset +: 8];
    load_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (size)
      SZ_BYTE: load_data = {{24{sign & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{sign & load_half[15]}}, load_half};
      default: load_data = rd_word;
    endcase
  end

  // The sweep and normal stores share one write port; they never overlap in time.
  always_comb begin
    mem_we    = 4'b0000;
    mem_widx  = word_idx;
    mem_wdata = store_data;
    if (!rst && state_q == ST_CLEAR) begin
      mem_we    = 4'b1111;
      mem_widx  = clr_idx_q;
      mem_wdata = '0;
    end else if (accept && WE && legal) begin
      mem_we = lane_en;
    end
  end

  // NOTE: the storage array has no reset; zeroing is the job of the clear sweep, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we[k]) mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ready_d    = ready_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    rd_d       = rd_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b1;
        if (accept) begin
          if (!legal) begin
            misalign_d = 1'b1;
            if (!WE) begin
              rvalid_d = 1'b1;
              rd_d     = '0;
            end
          end else if (!WE) begin
            rvalid_d = 1'b1;
            rd_d     = load_data;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_idx_q  <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      rd_q       <= rd_d;
    end
  end

  assign RD       = rd_q;
  assign rvalid   = rvalid_q;
  assign ready    = ready_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane: a byte-array reference model predicts
// every load/illegal response, and a monitor compares whatever the DUT presents.
module tb_data_mem_bytelane;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              WE;
  logic [1:0]        size;
  logic              sign;
  logic [ADDR_W-1:0] A;
  logic [31:0]       WD;
  logic [31:0]       RD;
  logic              rvalid;
  logic              ready;
  logic              misalign;

  data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .WE(WE), .size(size), .sign(sign),
    .A(A), .WD(WD), .RD(RD), .rvalid(rvalid), .ready(ready), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        mis;
    int          due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [DEPTH*4];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the oldest prediction, on the predicted cycle.
  always @(negedge clk) begin
    if (rvalid === 1'b1 || misalign === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_response", {30'd0, rvalid, misalign}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", cyc, e.due);
        check("rvalid", {31'd0, rvalid}, {31'd0, e.rv});
        check("misalign", {31'd0, misalign}, {31'd0, e.mis});
        if (e.rv) check("RD", RD, e.rd);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("missing_response", cyc, e.due + 1000000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_legal(input logic [1:0] sz, input int a);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  // Drive one request for one cycle and record what the model says should come back.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input int a, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic [31:0] v;
    req  = 1'b1;
    WE   = we;
    size = sz;
    sign = sg;
    A    = ADDR_W'(a);
    WD   = wd;
    n    = 1 << sz;
    e.due = cyc + 1;
    if (!model_legal(sz, a)) begin
      e.rv = !we; e.rd = 32'd0; e.mis = 1'b1;
      sb.push_back(e);
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rv = 1'b1; e.rd = v; e.mis = 1'b0;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts ready=0 cycles after reset deasserts; optionally fires requests mid-sweep that must be dropped.
  task automatic wait_sweep(input string name, input bit poke);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      req = 1'b0;
      if (poke && n == 50) begin
        req = 1'b1; WE = 1'b1; size = 2'd2; sign = 1'b0; A = 10'h000; WD = 32'hFFFF_FFFF;
      end
      if (poke && n == 51) begin
        req = 1'b1; WE = 1'b0; size = 2'd2; sign = 1'b0; A = 10'h000;
      end
      n++;
      tick();
    end
    req = 1'b0;
    check(name, n, DEPTH);
    check({name, "_ready_after"}, {31'd0, ready}, 32'd1);
    model_clear();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req = 1'b0;
    tick();
    check("rst_RD", RD, 32'd0);
    check("rst_flags", {29'd0, rvalid, misalign, ready}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; WE = 1'b0; size = 2'd0; sign = 1'b0; A = '0; WD = '0;
    model_clear();
    tick();
    tick();
    pulse_reset();
    wait_sweep("sweep_initial", 1'b0);

    // Reset sweep clears preloaded contents
    dut.mem[5] = 32'hDEADBEEF;
    tick();
    pulse_reset();
    wait_sweep("sweep_len", 1'b0);
    issue(1'b0, 2'd2, 1'b0, 'h14, 32'd0);
    idle(2);

    // Word, byte, halfword directed checks
    issue(1'b1, 2'd2, 1'b0, 'h20, 32'h1234_5678);
    issue(1'b0, 2'd2, 1'b0, 'h20, 32'd0);
    issue(1'b1, 2'd0, 1'b0, 'h23, 32'h0000_00AA);
    issue(1'b0, 2'd2, 1'b0, 'h20, 32'd0);
    issue(1'b0, 2'd0, 1'b1, 'h23, 32'd0);
    issue(1'b0, 2'd0, 1'b0, 'h23, 32'd0);
    issue(1'b1, 2'd1, 1'b0, 'h22, 32'h0000_8001);
    issue(1'b0, 2'd1, 1'b1, 'h22, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 'h20, 32'd0);
    // Illegal accesses, back to back
    issue(1'b1, 2'd2, 1'b0, 'h21, 32'hFFFF_FFFF);
    issue(1'b0, 2'd1, 1'b0, 'h23, 32'd0);
    issue(1'b0, 2'd3, 1'b0, 'h20, 32'd0);
    issue(1'b1, 2'd3, 1'b0, 'h20, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 1'b0, 'h20, 32'd0);
    idle(1);
    check("RD_hold", RD, 32'h8001_5678);
    idle(2);

    // Randomized traffic over a small window so stores and loads collide
    for (int i = 0; i < 500; i++) begin
      int          r;
      int          a;
      logic [1:0]  sz;
      r  = int'($urandom_range(0, 7));
      sz = (r < 7) ? 2'(r % 3) : 2'd3;
      a  = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);

    // Reset in the middle of the sweep restarts it; requests while not ready are dropped
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    pulse_reset();
    check("clr_idx_restart", 32'(dut.clr_idx_q), 32'd0);
    wait_sweep("sweep_after_midreset", 1'b1);
    issue(1'b0, 2'd2, 1'b0, 'h000, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 'h3FC, 32'd0);
    idle(3);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
